branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_cmp.sv | 39 +++
 rtl/branch_resolve_unit.sv | 108 ++++++++++
 tb/tb_branch_resolve_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: funct3 encodings,
// compare flags and the output-register state type.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } flags_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational compare: derives Z/N/V/C from rs1-rs2 and selects the
// branch condition for funct3. Undefined encodings report illegal, not taken.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    logic [XLEN:0] diff;
    flags_t        flags;

    always_comb begin
        // Extra top bit is the borrow out; C is its inverse (rs1 >= rs2 unsigned).
        diff    = {1'b0, rs1} - {1'b0, rs2};
        flags.z = (rs1 == rs2);
        flags.n = diff[XLEN-1];
        flags.v = (rs1[XLEN-1] ^ rs2[XLEN-1]) & (diff[XLEN-1] ^ rs1[XLEN-1]);
        flags.c = ~diff[XLEN];

        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = flags.z;
            F3_BNE:  taken = ~flags.z;
            F3_BLT:  taken = flags.n ^ flags.v;
            F3_BGE:  taken = ~(flags.n ^ flags.v);
            F3_BLTU: taken = ~flags.c;
            F3_BGEU: taken = flags.c;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: one registered result stage with valid/ready output,
// flush, and saturating retired-branch / mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             taken,
    output logic             illegal,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output state_t           dbg_state
);

    // Handshake: a transfer happens on a side only when valid and ready are
    // both high at the rising edge; flush cancels both transfers that cycle.
    logic   cmp_taken;
    logic   cmp_illegal;
    logic   accept;
    logic   retire;
    state_t state;
    state_t state_nxt;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign retire   = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_FULL;
                ST_FULL:  if (retire && !accept) state_nxt = ST_EMPTY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == ST_FULL);
        dbg_state = state;
    end

    // Result fields only load on accept, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken       <= 1'b0;
            illegal     <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else if (accept) begin
            taken       <= cmp_taken;
            illegal     <= cmp_illegal;
            mispredict  <= ~cmp_illegal & (cmp_taken ^ pred_taken);
            redirect_pc <= cmp_taken ? (pc + imm) : (pc + XLEN'(4));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (retire && !illegal) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic
// against a behavioural model; a CNT_W=4 copy shares the same stimulus.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, pred_taken, out_ready, flush, cnt_clr;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, imm;

    logic        in_ready, out_valid, taken, illegal, mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;
    state_t      dbg_state;

    logic        in_ready4, out_valid4, taken4, illegal4, mispredict4;
    logic [31:0] redirect_pc4;
    logic [3:0]  branch_cnt4, mispred_cnt4;
    state_t      dbg_state4;

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr), .taken(taken), .illegal(illegal),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .dbg_state(dbg_state)
    );

    branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .out_valid(out_valid4), .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr), .taken(taken4), .illegal(illegal4),
        .mispredict(mispredict4), .redirect_pc(redirect_pc4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4), .dbg_state(dbg_state4)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the output register and counters
    logic        m_valid, m_taken, m_illegal, m_mispred;
    logic [31:0] m_rpc;
    int          m_bcnt, m_mcnt, m_bcnt4, m_mcnt4;

    function automatic void resolve(input logic [2:0] f, input logic [31:0] a, b, p, im,
                                    input logic pt, output logic t, output logic il,
                                    output logic mp, output logic [31:0] r);
        t  = 1'b0;
        il = 1'b0;
        case (f)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = ($signed(a) < $signed(b));
            3'd5: t = ($signed(a) >= $signed(b));
            3'd6: t = (a < b);
            3'd7: t = (a >= b);
            default: il = 1'b1;
        endcase
        r  = t ? p + im : p + 32'd4;
        mp = il ? 1'b0 : (t ^ pt);
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic drive(input logic iv, input logic [2:0] f, input logic [31:0] a, b, p, im,
                         input logic pt, input logic ordy, input logic fl, input logic clr);
        in_valid = iv; funct3 = f; rs1 = a; rs2 = b; pc = p; imm = im;
        pred_taken = pt; out_ready = ordy; flush = fl; cnt_clr = clr;
        #1;
    endtask

    // Advance the model by one edge using the currently driven inputs, then the clock.
    task automatic step();
        logic rdy, ret, acc;
        if (reset) begin
            m_valid = 0; m_taken = 0; m_illegal = 0; m_mispred = 0; m_rpc = '0;
            m_bcnt = 0; m_mcnt = 0; m_bcnt4 = 0; m_mcnt4 = 0;
        end else begin
            rdy = !m_valid || out_ready;
            ret = m_valid && out_ready && !flush;
            acc = in_valid && rdy && !flush;
            if (cnt_clr) begin
                m_bcnt = 0; m_mcnt = 0; m_bcnt4 = 0; m_mcnt4 = 0;
            end else if (ret && !m_illegal) begin
                m_bcnt  = sat_inc(m_bcnt, 65535);
                m_bcnt4 = sat_inc(m_bcnt4, 15);
                if (m_mispred) begin
                    m_mcnt  = sat_inc(m_mcnt, 65535);
                    m_mcnt4 = sat_inc(m_mcnt4, 15);
                end
            end
            if (acc) begin
                resolve(funct3, rs1, rs2, pc, imm, pred_taken, m_taken, m_illegal, m_mispred, m_rpc);
                m_valid = 1;
            end else if (ret || flush) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h8, 0, 1, 1, 1);
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (taken !== 1'b0 || illegal !== 1'b0 || mispredict !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got t=%0b i=%0b m=%0b want 000", taken, illegal, mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        checks++; if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0 || branch_cnt4 !== 4'h0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0", branch_cnt, mispred_cnt, branch_cnt4); end
        reset = 0;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_signed_lt();
        drive(1, 3'b100, 32'h8000_0000, 32'h1, 32'h1000, 32'h40, 0, 0, 0, 0);
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL blt_out_valid: got %0b want 1", out_valid); end
        checks++; if (taken !== 1'b1 || mispredict !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL blt_flags: got t=%0b m=%0b i=%0b want 1 1 0", taken, mispredict, illegal); end
        checks++; if (redirect_pc !== 32'h1040) begin errors++; $display("FAIL blt_redirect_pc: got %h want 00001040", redirect_pc); end
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        checks++; if (out_valid !== 1'b0 || branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt)) begin
            errors++; $display("FAIL blt_retire: got v=%0b b=%0d m=%0d want 0 %0d %0d", out_valid, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
    endtask

    task automatic test_unsigned();
        drive(1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h2000, 32'h10, 0, 1, 0, 0);
        step();
        checks++; if (taken !== 1'b0 || redirect_pc !== 32'h2004) begin
            errors++; $display("FAIL bltu: got t=%0b pc=%h want 0 00002004", taken, redirect_pc); end
        drive(1, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h2000, 32'h10, 0, 1, 0, 0);
        step();
        checks++; if (taken !== 1'b1 || redirect_pc !== 32'h2010) begin
            errors++; $display("FAIL bgeu: got t=%0b pc=%h want 1 00002010", taken, redirect_pc); end
        drive(1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFC, 32'h10, 0, 1, 0, 0);
        step();
        checks++; if (taken !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL pc_wrap: got t=%0b pc=%h want 0 00000000", taken, redirect_pc); end
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
    endtask

    task automatic test_stall();
        int pb;
        drive(1, 3'b000, 32'd7, 32'd7, 32'h300, 32'h20, 0, 0, 0, 0);
        step();
        pb = m_bcnt;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'b001, 32'd3, 32'd4, 32'h400, 32'h8, 1, 0, 0, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 32'h320 || branch_cnt !== 16'(pb)) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%0b t=%0b m=%0b pc=%h b=%0d want 1 1 1 00000320 %0d",
                                   i, out_valid, taken, mispredict, redirect_pc, branch_cnt, pb); end
        end
        drive(1, 3'b001, 32'd3, 32'd4, 32'h400, 32'h8, 1, 1, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || mispredict !== 1'b0 || redirect_pc !== 32'h408 || branch_cnt !== 16'(pb + 1)) begin
            errors++; $display("FAIL b2b_result: got v=%0b t=%0b m=%0b pc=%h b=%0d want 1 1 0 00000408 %0d",
                               out_valid, taken, mispredict, redirect_pc, branch_cnt, pb + 1); end
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
    endtask

    task automatic test_illegal();
        int pb, pm;
        drive(1, 3'b010, 32'd5, 32'd5, 32'h500, 32'h10, 1, 1, 0, 0);
        step();
        checks++; if (illegal !== 1'b1 || taken !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h504) begin
            errors++; $display("FAIL illegal_result: got i=%0b t=%0b m=%0b pc=%h want 1 0 0 00000504", illegal, taken, mispredict, redirect_pc); end
        pb = m_bcnt; pm = m_mcnt;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        checks++; if (out_valid !== 1'b0 || branch_cnt !== 16'(pb) || mispred_cnt !== 16'(pm)) begin
            errors++; $display("FAIL illegal_uncounted: got v=%0b b=%0d m=%0d want 0 %0d %0d", out_valid, branch_cnt, mispred_cnt, pb, pm); end
    endtask

    task automatic test_flush();
        int pb, pm;
        drive(1, 3'b000, 32'd1, 32'd1, 32'h600, 32'h4, 0, 0, 0, 0);
        step();
        pb = m_bcnt; pm = m_mcnt;
        drive(1, 3'b000, 32'd2, 32'd2, 32'h700, 32'h4, 0, 1, 1, 0);
        step();
        checks++; if (out_valid !== 1'b0 || branch_cnt !== 16'(pb) || mispred_cnt !== 16'(pm)) begin
            errors++; $display("FAIL flush: got v=%0b b=%0d m=%0d want 0 %0d %0d", out_valid, branch_cnt, mispred_cnt, pb, pm); end
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %0b want 0", out_valid); end
    endtask

    task automatic test_saturate();
        reset = 1;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        reset = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 3'b000, 32'(i), 32'(i), 32'h800, 32'h10, 0, 1, 0, 0);
            step();
        end
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        checks++; if (branch_cnt4 !== 4'd15 || mispred_cnt4 !== 4'd15) begin
            errors++; $display("FAIL sat_cnt4: got %0d/%0d want 15/15", branch_cnt4, mispred_cnt4); end
        checks++; if (branch_cnt !== 16'd17 || mispred_cnt !== 16'd17) begin
            errors++; $display("FAIL sat_cnt16: got %0d/%0d want 17/17", branch_cnt, mispred_cnt); end
        drive(1, 3'b000, 32'd9, 32'd9, 32'h900, 32'h10, 0, 0, 0, 0);
        step();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1);
        step();
        checks++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || branch_cnt4 !== 4'd0 || mispred_cnt4 !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clr_priority: got %0d/%0d/%0d/%0d v=%0b want 0 0 0 0 0",
                               branch_cnt, mispred_cnt, branch_cnt4, mispred_cnt4, out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
            checks++; if (in_ready !== (!m_valid || out_ready)) begin
                errors++; $display("FAIL rnd_in_ready[%0d]: got %0b want %0b", i, in_ready, !m_valid || out_ready); end
            step();
            checks++; if (out_valid !== m_valid || out_valid4 !== m_valid) begin
                errors++; $display("FAIL rnd_out_valid[%0d]: got %0b want %0b", i, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (taken !== m_taken || illegal !== m_illegal || mispredict !== m_mispred || redirect_pc !== m_rpc) begin
                    errors++; $display("FAIL rnd_result[%0d]: got t=%0b i=%0b m=%0b pc=%h want %0b %0b %0b %h",
                                       i, taken, illegal, mispredict, redirect_pc, m_taken, m_illegal, m_mispred, m_rpc); end
            end
            checks++; if (branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt) ||
                          branch_cnt4 !== 4'(m_bcnt4) || mispred_cnt4 !== 4'(m_mcnt4)) begin
                errors++; $display("FAIL rnd_counters[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                                   branch_cnt, mispred_cnt, branch_cnt4, mispred_cnt4, m_bcnt, m_mcnt, m_bcnt4, m_mcnt4); end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        m_valid = 0; m_taken = 0; m_illegal = 0; m_mispred = 0; m_rpc = '0;
        m_bcnt = 0; m_mcnt = 0; m_bcnt4 = 0; m_mcnt4 = 0;
        test_reset();
        test_signed_lt();
        test_unsigned();
        test_stall();
        test_illegal();
        test_flush();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
